// File: rtl/bcd_adder_seq_if.sv
// Handshake and operand/result bundle for the digit-serial packed-BCD adder.
interface bcd_adder_seq_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic                  cin;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  neg;
    logic                  invalid;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, neg, invalid
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, neg, invalid
    );
endinterface

// File: rtl/bcd_adder_seq.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first,
// subtraction by ten's complement (nine's complement of B plus initial carry).
module bcd_adder_seq #(
    parameter int DIGITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    bcd_adder_seq_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic [W-1:0]    r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_sub;
    logic            r_carry;
    logic            r_inv_acc;
    logic            r_busy;
    logic            r_done;
    logic            r_cout;
    logic            r_neg;
    logic            r_invalid;

    logic [3:0]      w_ak;
    logic [3:0]      w_braw;
    logic [3:0]      w_bk;
    logic [3:0]      w_digit;
    logic [4:0]      w_s;
    logic            w_carry;
    logic            w_inv;
    logic            w_last;
    logic [W-1:0]    w_res;

    always_comb begin
        w_ak    = r_a[4*int'(r_idx) +: 4];
        w_braw  = r_b[4*int'(r_idx) +: 4];
        // 4-bit wrap gives (9 - b) mod 16 for out-of-range B digits
        w_bk    = r_sub ? (4'd9 - w_braw) : w_braw;
        w_s     = 5'(w_ak) + 5'(w_bk) + 5'(r_carry);
        w_carry = (w_s >= 5'd10);
        w_digit = w_carry ? 4'(w_s - 5'd10) : w_s[3:0];
        w_inv   = r_inv_acc | (w_ak > 4'd9) | (w_braw > 4'd9);
        w_res   = r_res;
        w_res[4*int'(r_idx) +: 4] = w_digit;
        w_last  = (int'(r_idx) == DIGITS - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_inv_acc <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cout    <= 1'b0;
            r_neg     <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_sub     <= bus.sub;
                        r_carry   <= bus.sub | bus.cin;
                        r_idx     <= '0;
                        r_inv_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_res     <= w_res;
                    r_carry   <= w_carry;
                    r_inv_acc <= w_inv;
                    r_idx     <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum     <= w_res;
                        r_cout    <= w_carry;
                        r_neg     <= r_sub & ~w_carry;
                        r_invalid <= w_inv;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.neg     = r_neg;
    assign bus.invalid = r_invalid;
endmodule
